// File: rtl/aes_addroundkey_stream.sv
// AES AddRoundKey stage with per-lane key application and a small output FIFO.
// Each accepted block is transformed immediately and queued; the FIFO head drives
// state_o. All outputs except in_ready_o come straight from registers.

module aes_addroundkey_stream #(
  parameter int unsigned LANES = 1,
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 in_valid_i,
  output logic                 in_ready_o,
  input  logic [LANES*128-1:0] state_i,
  input  logic [LANES*128-1:0] round_key_i,
  input  logic [LANES-1:0]     lane_en_i,
  input  logic [1:0]           mode_i,
  output logic                 out_valid_o,
  input  logic                 out_ready_i,
  output logic [LANES*128-1:0] state_o,
  output logic [31:0]          count_o,
  output logic                 err_o
);

  localparam int unsigned W  = LANES * 128;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [AW:0] OccFull = (AW + 1)'(DEPTH);

  localparam logic [1:0] ModeXor    = 2'b00;
  localparam logic [1:0] ModeBypass = 2'b01;
  localparam logic [1:0] ModeKeyOut = 2'b10;
  localparam logic [1:0] ModeRsvd   = 2'b11;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   occ_q, occ_d;
  logic [31:0]   count_q, count_d;
  logic          err_q, err_d;
  // Holds in_ready_o low until the first edge after reset is released.
  logic          ready_en_q;

  logic         full;
  logic         empty;
  logic         push;
  logic         pop;
  logic [W-1:0] result;

  assign full  = (occ_q == OccFull);
  assign empty = (occ_q == '0);

  assign in_ready_o  = ready_en_q && !full;
  assign out_valid_o = !empty;
  assign state_o     = empty ? '0 : mem_q[rd_ptr_q];
  assign count_o     = count_q;
  assign err_o       = err_q;

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // Per-lane transform of the sampled block; disabled lanes pass state through.
  always_comb begin
    result = state_i;
    for (int n = 0; n < LANES; n++) begin
      if (lane_en_i[n]) begin
        case (mode_i)
          ModeXor, ModeRsvd: result[n*128 +: 128] = state_i[n*128 +: 128]
                                                     ^ round_key_i[n*128 +: 128];
          ModeBypass:        result[n*128 +: 128] = state_i[n*128 +: 128];
          ModeKeyOut:        result[n*128 +: 128] = round_key_i[n*128 +: 128];
          default:           result[n*128 +: 128] = state_i[n*128 +: 128];
        endcase
      end
    end
  end

  // Next-state for pointers, occupancy, handshake counter and sticky error.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    count_d  = count_q;
    err_d    = err_q;

    // Pointers wrap naturally because DEPTH is a power of two.
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
      count_d  = count_q + 32'd1;
    end

    case ({push, pop})
      2'b10:   occ_d = occ_q + (AW + 1)'(1);
      2'b01:   occ_d = occ_q - (AW + 1)'(1);
      default: occ_d = occ_q;
    endcase

    if (push && (mode_i == ModeRsvd)) begin
      err_d = 1'b1;
    end
  end

  // Control state register with asynchronous reset.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      occ_q      <= '0;
      count_q    <= '0;
      err_q      <= 1'b0;
      ready_en_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      occ_q      <= occ_d;
      count_q    <= count_d;
      err_q      <= err_d;
      ready_en_q <= 1'b1;
    end
  end

  // Storage array; contents are only visible when occupancy says they are valid.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= result;
    end
  end

endmodule

// File: tb/tb_aes_addroundkey_stream.sv
// Directed bench for aes_addroundkey_stream: one single-lane and one dual-lane instance.

module tb_aes_addroundkey_stream;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // Single-lane instance
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [127:0] st_in = '0;
  logic [127:0] key_in = '0;
  logic [0:0]   lane_en = 1'b1;
  logic [1:0]   mode = 2'b00;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] st_out;
  logic [31:0]  count;
  logic         err;

  // Dual-lane instance
  logic         in_valid2 = 1'b0;
  logic         in_ready2;
  logic [255:0] st_in2 = '0;
  logic [255:0] key_in2 = '0;
  logic [1:0]   lane_en2 = 2'b01;
  logic [1:0]   mode2 = 2'b00;
  logic         out_valid2;
  logic         out_ready2 = 1'b0;
  logic [255:0] st_out2;
  logic [31:0]  count2;
  logic         err2;

  int total = 0;
  int bad = 0;

  logic [127:0] sv [100];
  logic [127:0] kv [100];
  logic [127:0] ev [100];
  logic [1:0]   mv [100];
  logic         lv [100];

  localparam logic [127:0] Fips = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FOut = 128'h00102030405060708090a0b0c0d0e0f0;
  localparam logic [127:0] SA   = 128'h0123456789abcdef0123456789abcdef;
  localparam logic [127:0] KA   = 128'hffffffff00000000ffffffff00000000;
  localparam logic [127:0] SB   = 128'h11111111222222223333333344444444;
  localparam logic [127:0] KB   = 128'hdeadbeefcafef00d0badc0de12345678;
  localparam logic [127:0] SC   = 128'ha5a5a5a55a5a5a5aa5a5a5a55a5a5a5a;
  localparam logic [127:0] KC   = 128'h0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f0f;

  aes_addroundkey_stream #(.LANES(1), .DEPTH(2)) u_dut1 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .state_i    (st_in),
    .round_key_i(key_in),
    .lane_en_i  (lane_en),
    .mode_i     (mode),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .state_o    (st_out),
    .count_o    (count),
    .err_o      (err)
  );

  aes_addroundkey_stream #(.LANES(2), .DEPTH(2)) u_dut2 (
    .clk_i      (clk),
    .rst_i      (rst),
    .in_valid_i (in_valid2),
    .in_ready_o (in_ready2),
    .state_i    (st_in2),
    .round_key_i(key_in2),
    .lane_en_i  (lane_en2),
    .mode_i     (mode2),
    .out_valid_o(out_valid2),
    .out_ready_i(out_ready2),
    .state_o    (st_out2),
    .count_o    (count2),
    .err_o      (err2)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [127:0] s, input logic [127:0] k, input logic [1:0] m,
                       input logic le);
    in_valid = 1'b1;
    st_in    = s;
    key_in   = k;
    mode     = m;
    lane_en  = le;
  endtask

  initial begin
    // Reset held, no clock edge yet
    #3;
    chk("rst_valid", 256'(out_valid), 256'(1'b0));
    chk("rst_ready", 256'(in_ready), 256'(1'b0));
    chk("rst_state", 256'(st_out), 256'(0));
    chk("rst_count", 256'(count), 256'(0));
    chk("rst_err", 256'(err), 256'(1'b0));
    step();
    step();
    chk("rst_ready_clk", 256'(in_ready), 256'(1'b0));
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_before_edge", 256'(in_ready), 256'(1'b0));
    step();
    chk("ready_after_edge", 256'(in_ready), 256'(1'b1));

    // FIPS-197 round 0 vector, then hold under backpressure
    drive(Fips, FKey, 2'b00, 1'b1);
    step();
    in_valid = 1'b0;
    chk("fips_valid", 256'(out_valid), 256'(1'b1));
    chk("fips_state", 256'(st_out), 256'(FOut));
    step();
    chk("hold_valid", 256'(out_valid), 256'(1'b1));
    chk("hold_state", 256'(st_out), 256'(FOut));
    out_ready = 1'b1;
    step();
    chk("pop1_count", 256'(count), 256'(1));
    chk("pop1_empty", 256'(out_valid), 256'(1'b0));
    chk("pop1_zero", 256'(st_out), 256'(0));

    // Self-inverse
    drive(FOut, FKey, 2'b00, 1'b1);
    step();
    in_valid = 1'b0;
    chk("inv_state", 256'(st_out), 256'(Fips));
    step();
    chk("inv_count", 256'(count), 256'(2));

    // Reserved mode: XOR plus sticky error
    chk("err_pre", 256'(err), 256'(1'b0));
    drive(SA, KA, 2'b11, 1'b1);
    step();
    in_valid = 1'b0;
    chk("rsvd_state", 256'(st_out), 256'(SA ^ KA));
    chk("rsvd_err", 256'(err), 256'(1'b1));
    step();
    step();
    chk("err_sticky", 256'(err), 256'(1'b1));

    // Dual lane: only lane 0 enabled
    chk("l2_err_pre", 256'(err2), 256'(1'b0));
    in_valid2  = 1'b1;
    out_ready2 = 1'b1;
    st_in2     = '0;
    key_in2    = '1;
    lane_en2   = 2'b01;
    mode2      = 2'b00;
    step();
    chk("l2_xor", st_out2, {128'h0, {128{1'b1}}});
    mode2 = 2'b11;
    step();
    in_valid2 = 1'b0;
    chk("l2_rsvd", st_out2, {128'h0, {128{1'b1}}});
    chk("l2_err", 256'(err2), 256'(1'b1));
    step();
    chk("l2_count", 256'(count2), 256'(2));

    // Reset clears state, then backpressure with A/B/C in bypass/key-out/disabled
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst2_err", 256'(err), 256'(1'b0));
    chk("rst2_count", 256'(count), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b0;
    step();
    drive(SA, KA, 2'b01, 1'b1);
    step();
    chk("bp_ready_a", 256'(in_ready), 256'(1'b1));
    chk("bp_head_a", 256'(st_out), 256'(SA));
    drive(SB, KB, 2'b10, 1'b1);
    step();
    chk("bp_full_ready", 256'(in_ready), 256'(1'b0));
    chk("bp_head_a2", 256'(st_out), 256'(SA));
    drive(SC, KC, 2'b00, 1'b0);
    step();
    chk("bp_still_full", 256'(in_ready), 256'(1'b0));
    chk("bp_head_a3", 256'(st_out), 256'(SA));
    out_ready = 1'b1;
    step();
    chk("bp_head_b", 256'(st_out), 256'(KB));
    chk("bp_ready_b", 256'(in_ready), 256'(1'b1));
    chk("bp_count1", 256'(count), 256'(1));
    step();
    in_valid = 1'b0;
    chk("bp_head_c", 256'(st_out), 256'(SC));
    chk("bp_occ_same", 256'(out_valid), 256'(1'b1));
    step();
    chk("bp_empty", 256'(out_valid), 256'(1'b0));
    chk("bp_count3", 256'(count), 256'(3));

    // Reset mid-operation with two entries queued
    out_ready = 1'b0;
    drive(SA, KA, 2'b11, 1'b1);
    step();
    drive(SB, KB, 2'b00, 1'b1);
    step();
    in_valid = 1'b0;
    chk("mid_err_set", 256'(err), 256'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("mid_valid", 256'(out_valid), 256'(1'b0));
    chk("mid_count", 256'(count), 256'(0));
    chk("mid_err", 256'(err), 256'(1'b0));
    chk("mid_ready", 256'(in_ready), 256'(1'b0));
    chk("mid_state", 256'(st_out), 256'(0));
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("post_rst_valid", 256'(out_valid), 256'(1'b0));
    end
    chk("post_rst_count", 256'(count), 256'(0));

    // Streaming: 100 blocks back-to-back with mixed modes
    for (int i = 0; i < 100; i++) begin
      sv[i] = {$urandom, $urandom, $urandom, $urandom};
      kv[i] = {$urandom, $urandom, $urandom, $urandom};
      mv[i] = 2'($urandom_range(0, 2));
      lv[i] = 1'($urandom_range(0, 1));
      if (!lv[i] || mv[i] == 2'b01) ev[i] = sv[i];
      else if (mv[i] == 2'b10)      ev[i] = kv[i];
      else                          ev[i] = sv[i] ^ kv[i];
    end
    drive(sv[0], kv[0], mv[0], lv[0]);
    for (int i = 0; i < 100; i++) begin
      step();
      chk("stream_valid", 256'(out_valid), 256'(1'b1));
      chk("stream_state", 256'(st_out), 256'(ev[i]));
      if (i < 99) drive(sv[i+1], kv[i+1], mv[i+1], lv[i+1]);
      else        in_valid = 1'b0;
    end
    step();
    chk("stream_count", 256'(count), 256'(100));
    chk("stream_empty", 256'(out_valid), 256'(1'b0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aes_addroundkey_stream.md
AES_ADDROUNDKEY_STREAM -- requirements
Module: aes_addroundkey_stream

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 Parameter LANES, default 1, SHALL set the number of independent 128-bit lanes (legal range 1..4).
REQ-003 Parameter DEPTH, default 2, SHALL set the output FIFO entry count (power of two, >=2).
REQ-004 clk_i  input  1  SHALL be the rising-edge clock for all state.
REQ-005 rst_i  input  1  SHALL be the asynchronous active-high reset.
REQ-006 in_valid_i  input  1  SHALL indicate that the input block and key are valid.
REQ-007 in_ready_o  output  1  SHALL indicate that the FIFO can accept a block.
REQ-008 state_i  input  LANES*128  SHALL carry the input state (lane n at bits [n*128 +: 128]).
REQ-009 round_key_i  input  LANES*128  SHALL carry the per-lane round key, using the same packing as state_i.
REQ-010 lane_en_i  input  LANES  SHALL select the lanes that apply the key (bit n is lane n).
REQ-011 mode_i  input  2  SHALL select the operation: 00 XOR, 01 bypass, 10 key-out, 11 reserved.
REQ-012 out_valid_o  output  1  SHALL indicate that the FIFO head is valid.
REQ-013 out_ready_i  input  1  SHALL indicate that the consumer accepts the head.
REQ-014 state_o  output  LANES*128  SHALL present the FIFO head result.
REQ-015 count_o  output  32  SHALL hold the number of completed output handshakes.
REQ-016 err_o  output  1  SHALL be a sticky flag for reserved-mode use.

Function
REQ-017 Accept SHALL occur only when in_valid_i && in_ready_o at a rising edge.
REQ-018 Pop SHALL occur only when out_valid_o && out_ready_i at a rising edge.
REQ-019 The per-lane result SHALL be computed at accept from the sampled inputs as follows:
- lane disabled: state unchanged;
- mode 00 or 11: state XOR key;
- mode 01: state unchanged;
- mode 10: key.
REQ-020 Mode 11 at accept SHALL behave as XOR and SHALL set err_o.
REQ-021 err_o SHALL be cleared only by reset.
REQ-022 Latency SHALL be 1 cycle: a block accepted into an empty FIFO appears with out_valid_o=1 on the next cycle.
REQ-023 in_ready_o SHALL equal !full, registered-derived, with no combinational path from out_ready_i.
REQ-024 When full, in_ready_o SHALL be 0, and a same-cycle pop SHALL not enable a push in that cycle.
REQ-025 A simultaneous accept and pop with a non-empty FIFO SHALL leave occupancy unchanged.
REQ-026 A simultaneous accept and pop SHALL deliver data in strict FIFO order.
REQ-027 When empty, out_valid_o SHALL be 0 and state_o SHALL be all zeros.
REQ-028 out_valid_o and state_o SHALL stay stable while out_valid_o && !out_ready_i.
REQ-029 Read and write pointers SHALL wrap modulo DEPTH.
REQ-030 Occupancy SHALL be tracked in clog2(DEPTH)+1 bits.
REQ-031 count_o SHALL increment by 1 per pop and wrap from FFFFFFFF to 00000000.
REQ-032 The block SHALL have no combinational path from any input to out_valid_o, state_o, count_o or err_o.

Reset
REQ-033 While rst_i=1, regardless of clock:
- FIFO empty;
- out_valid_o=0, in_ready_o=0;
- state_o=0, count_o=0, err_o=0.
REQ-034 in_ready_o SHALL rise on the first rising edge after rst_i deasserts.
REQ-035 Reset asserted with entries pending SHALL discard them, and no stale entry SHALL appear after reset.

Verification
REQ-036 FIPS-197 round 0 vector: LANES=1, mode 00, lane_en=1, state 00112233445566778899aabbccddeeff, key 000102030405060708090a0b0c0d0e0f -> next cycle out_valid_o=1, state_o=00102030405060708090a0b0c0d0e0f0.
REQ-037 Backpressure: DEPTH=2, out_ready_i=0, push A, B, C -> in_ready_o=0 after B; raise out_ready_i -> A, B, C emerge in order; count_o=3.
REQ-038 Self-inverse: feed the REQ-036 output back with the same key -> state_o=00112233445566778899aabbccddeeff.
REQ-039 Lanes/modes: LANES=2, lane_en=01, mode 00, both keys all-ones, both states 0 -> lane0 all-ones, lane1 zero; mode 11 -> same data and err_o=1.
REQ-040 Reset mid-operation: two entries queued, pulse rst_i between clock edges -> out_valid_o=0, count_o=0, err_o=0 immediately; nothing is output afterwards.
REQ-041 Streaming: hold out_ready_i=1 and in_valid_i=1 for 100 cycles with the Random-1 vectors -> one output per cycle, count_o=100.
